// File: rtl/itype_pkg.sv
// Shared decode constants, field slices and the issue-stage payload for the I-type issue unit.
package itype_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned IMM_W  = 12;

  localparam logic [OPC_W-1:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [F3_W-1:0]   F3_ADDI    = 3'b000;
  localparam logic [REG_AW-1:0] REG_ZERO   = 5'd0;

  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_MSB  = 14;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned IMM_LSB = 20;
  localparam int unsigned IMM_MSB = 31;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [F3_W-1:0]   f3;
    logic [IMM_W-1:0]  imm;
    logic              legal;
  } iss_t;

  // Slice a raw word into the issue payload; only ADDI is marked legal.
  function automatic iss_t decode(input logic [ILEN-1:0] w, input logic v);
    iss_t d;
    d.valid = v;
    d.rd    = w[RD_MSB:RD_LSB];
    d.rs1   = w[RS1_MSB:RS1_LSB];
    d.f3    = w[F3_MSB:F3_LSB];
    d.imm   = w[IMM_MSB:IMM_LSB];
    d.legal = (w[OPC_MSB:0] == OPC_OP_IMM) && (w[F3_MSB:F3_LSB] == F3_ADDI);
    return d;
  endfunction

endpackage

// File: rtl/itype_regfile.sv
// 32x32 register file: rs1 and debug read ports (write-first), one write port, x0 hardwired to zero.
module itype_regfile
  import itype_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next-state array doubles as the write-first read source.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we && (waddr != REG_ZERO)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rs1_data = (rs1_addr == REG_ZERO) ? '0 : regs_d[rs1_addr];
  assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs_d[dbg_addr];

endmodule

// File: rtl/itype_issue_unit.sv
// I-type issue unit: decode -> ISS (drives ALU) -> WB (writes ALU result to rd).
// Build option ITYPE_FWD_EN: forward alu_result on an ISS/WB hazard instead of holding ISS a cycle.
module itype_issue_unit
  import itype_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [ILEN-1:0]   instr,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [F3_W-1:0]   alu_func3,
  output logic [XLEN-1:0]   alu_a,
  output logic [IMM_W-1:0]  alu_imm,
  input  logic [XLEN-1:0]   alu_result,
  output logic              retire_valid,
  output logic [REG_AW-1:0] retire_rd,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [XLEN-1:0]   dbg_rdata
);

  iss_t              iss_q, iss_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   rf_rs1_data;
  logic              hazard, stall, issuing;

  itype_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (iss_q.rs1),
    .rs1_data (rf_rs1_data),
    .dbg_addr (dbg_raddr),
    .dbg_data (dbg_rdata),
    .we       (wb_valid_q),
    .waddr    (wb_rd_q),
    .wdata    (alu_result)
  );

  // Issue control; illegal words drain from ISS in one cycle without issuing.
  always_comb begin
    hazard = iss_q.valid && iss_q.legal && wb_valid_q &&
             (wb_rd_q != REG_ZERO) && (iss_q.rs1 == wb_rd_q);
`ifdef ITYPE_FWD_EN
    stall = 1'b0;
    alu_a = hazard ? alu_result : rf_rs1_data;
`else
    stall = hazard;
    alu_a = rf_rs1_data;
`endif
    issuing      = iss_q.valid && iss_q.legal && !stall;
    instr_ready  = !iss_q.valid || !iss_q.legal || issuing;
    alu_opcode   = issuing ? OPC_OP_IMM : '0;
    alu_func3    = iss_q.f3;
    alu_imm      = iss_q.imm;
    illegal      = iss_q.valid && !iss_q.legal;
    retire_valid = wb_valid_q;
    retire_rd    = wb_rd_q;
    iss_d        = instr_ready ? decode(instr, instr_valid) : iss_q;
    wb_valid_d   = issuing;
    wb_rd_d      = iss_q.rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
    end else begin
      iss_q      <= iss_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

endmodule

// File: tb/tb_itype_issue_unit.sv
// Scoreboard bench for itype_issue_unit with a registered ALU model and an architectural register model.
module tb_itype_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic [31:0] alu_a;
  logic [11:0] alu_imm;
  logic [31:0] alu_result;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic        illegal;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;

  itype_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_a(alu_a),
    .alu_imm(alu_imm), .alu_result(alu_result), .retire_valid(retire_valid),
    .retire_rd(retire_rd), .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // ALU: registered a + zero-extended imm, holds on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_result <= '0;
    else if (alu_opcode == 7'b0010011) alu_result <= alu_a + {20'b0, alu_imm};
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          rt_cyc[$];
  int          ill_pending = 0;
  logic [31:0] ref_regs [32];
  int          vec = 0;
  int          err = 0;
  int          cyc_n = 0;
`ifdef ITYPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one accepted word, in program order.
  task automatic model(input logic [31:0] w);
    exp_t e;
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) begin
      e.rd  = w[11:7];
      e.val = ref_regs[w[19:15]] + {20'b0, w[31:20]};
      if (e.rd != 5'd0) ref_regs[e.rd] = e.val;
      exp_q.push_back(e);
    end else begin
      ill_pending++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst_n) begin
        if (retire_valid) begin
          rt_cyc.push_back(cyc_n);
          if (exp_q.size() == 0) begin
            chk("retire_unexpected", {27'b0, retire_rd}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("retire_rd", {27'b0, retire_rd}, {27'b0, e.rd});
            chk("retire_value", alu_result, e.val);
          end
        end
        if (illegal) begin
          chk("illegal_expected", 32'(ill_pending > 0), 32'd1);
          if (ill_pending > 0) ill_pending--;
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] w);
    int waits = 0;
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_within_bound", 32'(instr_ready), 32'd1);
    if (instr_ready) model(w);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      #1;
      chk(name, dbg_rdata, ref_regs[i]);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    ill_pending = 0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
  endtask

  initial begin
    logic [31:0] w;
    clear_model();
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_instr_ready", 32'(instr_ready), 32'd1);
    chk("reset_retire_valid", 32'(retire_valid), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_alu_opcode", {25'b0, alu_opcode}, 32'd0);
    sweep("reset_regs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5: retire the cycle after ISS
    send(32'h0050_0093);
    @(negedge clk);
    chk("latency_retire_valid", 32'(retire_valid), 32'd1);
    chk("latency_retire_rd", {27'b0, retire_rd}, 32'd1);
    @(negedge clk);
    sweep("addi_x1");

    // Zero-extended immediate
    send(32'hFFF0_0113);
    repeat (3) @(negedge clk);
    sweep("addi_x2_zext");

    // Dependent back-to-back pair
    rt_cyc.delete();
    send(32'h0050_0093);
    send(32'h0030_8093);
    chk("hazard_instr_ready", 32'(instr_ready), FWD ? 32'd1 : 32'd0);
    repeat (4) @(negedge clk);
    chk("hazard_retire_count", 32'(rt_cyc.size()), 32'd2);
    if (rt_cyc.size() == 2) chk("hazard_retire_spacing", 32'(rt_cyc[1] - rt_cyc[0]), FWD ? 32'd1 : 32'd2);
    sweep("hazard_x1");

    // Illegal words
    send(32'h0000_0033);
    send(32'h0050_2093);
    repeat (3) @(negedge clk);
    chk("illegal_drained", 32'(ill_pending), 32'd0);
    sweep("illegal_regs");

    // Randomized mix with frequent register dependences
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 3) repeat ($urandom_range(1, 2)) @(negedge clk);
      if ($urandom_range(0, 9) < 8) begin
        w = enc(12'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end else begin
        w = $urandom;
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) w[12] = 1'b1;
      end
      send(w);
    end
    repeat (4) @(negedge clk);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    sweep("random_regs");

    // x0 write with reset landing mid-stream
    send(32'h0090_0293);
    send(32'h0070_0013);
    #2;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_no_retire", 32'(retire_valid), 32'd0);
    end
    sweep("post_reset_regs");

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
